data_port_arbiter: RTL and testbench
====================================

DATA_PORT_ARBITER -- requirements
Module: data_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, cycles in BUSY without d_ack before aborting a transfer (2..255).
REQ-002 clk  input  1  sole clock; all state on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cpu_access, cpu_wr_en  input  1 each  CPU data master request / write qualifier.
REQ-005 cpu_addr, cpu_wr_val  input  32 each; cpu_bytesel  input  4  CPU address, write data, byte lanes.
REQ-006 cpu_data  output  32; cpu_ack, cpu_err  output  1 each  CPU read data, completion, abort flag.
REQ-007 dbg_access, dbg_wr_en, dbg_addr, dbg_wr_val, dbg_bytesel, dbg_data, dbg_ack, dbg_err: debug master, same directions and widths as cpu_*.
REQ-008 d_access, d_cs, d_wr_en  output  1 each; d_addr, d_wr_val  output  32; d_bytesel  output  4  shared RAM data port.
REQ-009 d_data  input  32; d_ack  input  1  RAM read data and completion.

Function
REQ-010 States: IDLE, BUSY_CPU, BUSY_DBG; exactly one state active.
REQ-011 IDLE with any *_access high: select winner, latch its addr/bytesel/wr_val/wr_en into slave registers, next state BUSY_<winner>.
REQ-012 d_access and d_cs shall be registered, high for every cycle of BUSY_*, low in IDLE; first asserted the cycle after the request is seen.
REQ-013 Slave address/data/bytesel/wr_en shall remain stable throughout BUSY_*; master inputs are ignored after latching.
REQ-014 In BUSY_x with d_ack high: x_ack high combinationally that cycle, x_data = d_data, x_err low; next state IDLE.
REQ-015 Non-granted master ack/err low, its data 32'h0; granted master data 32'h0 except on ack cycle.
REQ-016 Masters hold *_access until ack; minimum request-to-ack latency 2 cycles; back-to-back grants need one IDLE cycle between transfers.
REQ-017 8-bit timeout counter clears on entering BUSY_*, increments each BUSY cycle without d_ack.
REQ-018 Counter reaching TIMEOUT_CYCLES without d_ack: x_ack and x_err high one cycle, x_data 32'h0, d_access/d_cs drop next cycle, next state IDLE.
REQ-019 d_ack on the same cycle as timeout: normal completion wins, err low.
REQ-020 d_ack in IDLE is ignored; no master ack generated.
REQ-021 Master dropping access mid-transfer (protocol violation): transfer still completes; ack issued regardless.

Reset
REQ-022 rst_n low: state IDLE, counter 0, all outputs 0 (d_*, *_ack, *_err, *_data) immediately, asynchronously.
REQ-023 Reset asserted mid-transfer aborts it with no ack; first grant possible the second posedge after rst_n rises.

Configuration
REQ-024 Macro DATA_ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE grant the master not granted last; last-grant pointer resets to CPU (dbg wins first tie).
REQ-025 Macro undefined: fixed priority, dbg always wins ties; no last-grant pointer implemented.

Verification
REQ-026 CPU read addr 0x40, bytesel 0xF, RAM holds 0xDEADBEEF, ack after 1 cycle -> d_access at cycle 1, cpu_ack at cycle 2 with cpu_data 0xDEADBEEF, cpu_err 0.
REQ-027 CPU and dbg request same cycle, both hold for three transfers -> macro defined: grants dbg, cpu, dbg; undefined: dbg, dbg, dbg with cpu_ack never asserted.
REQ-028 dbg write 0x12345678 bytesel 0x3 to 0x100, d_ack withheld -> after 16 BUSY cycles dbg_ack=1, dbg_err=1, dbg_data 0; d_access low next cycle.
REQ-029 d_ack asserted exactly on 16th BUSY cycle -> dbg_ack=1, dbg_err=0.
REQ-030 rst_n pulsed low during BUSY_CPU -> all outputs 0 within same cycle, no cpu_ack; pending request re-granted after release.

Source files
------------

// File: rtl/data_port_arbiter.sv
// Two-master (CPU, debug) arbiter for a single RAM data port with a per-transfer timeout.
// Optional macro DATA_ARB_ROUND_ROBIN_EN: round-robin on ties; default build gives dbg fixed priority.
module data_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        cpu_access,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wr_val,
  input  logic [3:0]  cpu_bytesel,
  output logic [31:0] cpu_data,
  output logic        cpu_ack,
  output logic        cpu_err,

  input  logic        dbg_access,
  input  logic        dbg_wr_en,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wr_val,
  input  logic [3:0]  dbg_bytesel,
  output logic [31:0] dbg_data,
  output logic        dbg_ack,
  output logic        dbg_err,

  output logic        d_access,
  output logic        d_cs,
  output logic        d_wr_en,
  output logic [31:0] d_addr,
  output logic [31:0] d_wr_val,
  output logic [3:0]  d_bytesel,
  input  logic [31:0] d_data,
  input  logic        d_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_CPU = 2'd1,
    BUSY_DBG = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  tmo_cnt_q;
  logic        grant_ok_q;
  logic        d_access_q;
  logic        d_wr_en_q;
  logic [31:0] d_addr_q;
  logic [31:0] d_wr_val_q;
  logic [3:0]  d_bytesel_q;

  logic cpu_busy;
  logic dbg_busy;
  logic busy;
  logic expire;
  logic finish;
  logic start;
  logic pick_dbg;

  assign cpu_busy = (state_q == BUSY_CPU);
  assign dbg_busy = (state_q == BUSY_DBG);
  assign busy     = cpu_busy || dbg_busy;
  // A d_ack on the last allowed cycle still counts as a normal completion.
  assign expire   = busy && !d_ack && (tmo_cnt_q == TMO_LAST);
  assign finish   = busy && (d_ack || expire);
  // grant_ok_q holds off grants until the second edge after reset release.
  assign start    = grant_ok_q && (state_q == IDLE) && (cpu_access || dbg_access);

`ifdef DATA_ARB_ROUND_ROBIN_EN
  logic last_dbg_q;

  assign pick_dbg = dbg_access && (!cpu_access || !last_dbg_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dbg_q <= 1'b0;
    end else if (start) begin
      last_dbg_q <= pick_dbg;
    end
  end
`else
  assign pick_dbg = dbg_access;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmo_cnt_q   <= 8'd0;
      grant_ok_q  <= 1'b0;
      d_access_q  <= 1'b0;
      d_wr_en_q   <= 1'b0;
      d_addr_q    <= 32'h0;
      d_wr_val_q  <= 32'h0;
      d_bytesel_q <= 4'h0;
    end else begin
      grant_ok_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= pick_dbg ? BUSY_DBG : BUSY_CPU;
            tmo_cnt_q   <= 8'd0;
            d_access_q  <= 1'b1;
            d_wr_en_q   <= pick_dbg ? dbg_wr_en   : cpu_wr_en;
            d_addr_q    <= pick_dbg ? dbg_addr    : cpu_addr;
            d_wr_val_q  <= pick_dbg ? dbg_wr_val  : cpu_wr_val;
            d_bytesel_q <= pick_dbg ? dbg_bytesel : cpu_bytesel;
          end
        end
        BUSY_CPU, BUSY_DBG: begin
          if (finish) begin
            state_q    <= IDLE;
            d_access_q <= 1'b0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= IDLE;
          d_access_q <= 1'b0;
        end
      endcase
    end
  end

  assign d_access  = d_access_q;
  assign d_cs      = d_access_q;
  assign d_wr_en   = d_wr_en_q;
  assign d_addr    = d_addr_q;
  assign d_wr_val  = d_wr_val_q;
  assign d_bytesel = d_bytesel_q;

  assign cpu_ack  = cpu_busy && finish;
  assign cpu_err  = cpu_busy && expire;
  assign cpu_data = (cpu_busy && d_ack) ? d_data : 32'h0;

  assign dbg_ack  = dbg_busy && finish;
  assign dbg_err  = dbg_busy && expire;
  assign dbg_data = (dbg_busy && d_ack) ? d_data : 32'h0;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Bench for data_port_arbiter: vector table, directed corner sequences, randomized traffic vs. a transfer-level model.
// Honours DATA_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_data_port_arbiter;

  localparam int TMO = 16;
`ifdef DATA_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_access, cpu_wr_en, dbg_access, dbg_wr_en;
  logic [31:0] cpu_addr, cpu_wr_val, dbg_addr, dbg_wr_val;
  logic [3:0]  cpu_bytesel, dbg_bytesel;
  logic [31:0] cpu_data, dbg_data;
  logic        cpu_ack, cpu_err, dbg_ack, dbg_err;
  logic        d_access, d_cs, d_wr_en;
  logic [31:0] d_addr, d_wr_val, d_data;
  logic [3:0]  d_bytesel;
  logic        d_ack;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_access(cpu_access), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wr_val(cpu_wr_val), .cpu_bytesel(cpu_bytesel),
    .cpu_data(cpu_data), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .dbg_access(dbg_access), .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr),
    .dbg_wr_val(dbg_wr_val), .dbg_bytesel(dbg_bytesel),
    .dbg_data(dbg_data), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .d_access(d_access), .d_cs(d_cs), .d_wr_en(d_wr_en), .d_addr(d_addr),
    .d_wr_val(d_wr_val), .d_bytesel(d_bytesel), .d_data(d_data), .d_ack(d_ack)
  );

  typedef struct {
    logic        ca;
    logic        cw;
    logic [31:0] caddr;
    logic        da;
    logic        dack;
    logic [31:0] ddata;
    logic        e_dacc;
    logic [31:0] e_daddr;
    logic        e_dwr;
    logic [3:0]  e_dbs;
    logic        e_cack;
    logic [31:0] e_cdata;
    logic        e_gack;
    logic [31:0] e_gdata;
  } vec_t;

  vec_t vecs[12];

  // Transfer-level reference: who owns the port, how long it has waited, what it asked for.
  int          m_own;   // 0 none, 1 cpu, 2 dbg
  int          m_age;
  int          m_last;
  logic [31:0] m_addr, m_val;
  logic        m_wr;
  logic [3:0]  m_bs;
  logic        c_pend, g_pend;

  int exp_order[3];
  int got[3];
  int n_got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cpu_ack) $display("txn cpu addr=%08h data=%08h err=%b", d_addr, cpu_data, cpu_err);
    if (dbg_ack) $display("txn dbg addr=%08h data=%08h err=%b", d_addr, dbg_data, dbg_err);
  end

  task automatic dbg_timeout_seq(input int ack_at);
    next_cycle();
    cpu_access = 1'b0;
    dbg_access = 1'b1;
    d_ack      = 1'b0;
    d_data     = 32'hBAD0BAD0;
    settle();
    chk("tmo_req_idle", d_access, 1'b0);
    for (int n = 1; n <= TMO; n++) begin
      next_cycle();
      d_ack  = (n == ack_at);
      d_data = (n == ack_at) ? 32'hCAFEF00D : 32'hBAD0BAD0;
      settle();
      chk("tmo_dacc", d_access, 1'b1);
      if (n == 1) begin
        chk("tmo_daddr", d_addr, 32'h100);
        chk("tmo_dval", d_wr_val, 32'h12345678);
        chk("tmo_dbs", d_bytesel, 4'h3);
        chk("tmo_dwr", d_wr_en, 1'b1);
      end
      if (n < TMO) chk("tmo_early_ack", dbg_ack, 1'b0);
    end
    chk("tmo_ack", dbg_ack, 1'b1);
    chk("tmo_err", dbg_err, (ack_at == TMO) ? 1'b0 : 1'b1);
    chk("tmo_data", dbg_data, (ack_at == TMO) ? 32'hCAFEF00D : 32'h0);
    chk("tmo_cpu_ack", cpu_ack, 1'b0);
    next_cycle();
    dbg_access = 1'b0;
    d_ack      = 1'b0;
    settle();
    chk("tmo_dacc_drop", d_access, 1'b0);
    chk("tmo_ack_drop", dbg_ack, 1'b0);
  endtask

  task automatic model_cycle();
    logic busy, expire, fin;
    busy   = (m_own != 0);
    expire = busy && !d_ack && (m_age == TMO - 1);
    fin    = busy && (d_ack || expire);
    chk("m_dacc", d_access, busy);
    chk("m_dcs", d_cs, busy);
    if (busy) begin
      chk("m_daddr", d_addr, m_addr);
      chk("m_dwr", d_wr_en, m_wr);
      chk("m_dval", d_wr_val, m_val);
      chk("m_dbs", d_bytesel, m_bs);
    end
    chk("m_cack", cpu_ack, (m_own == 1) && fin);
    chk("m_cerr", cpu_err, (m_own == 1) && expire);
    chk("m_cdata", cpu_data, ((m_own == 1) && d_ack) ? d_data : 32'h0);
    chk("m_gack", dbg_ack, (m_own == 2) && fin);
    chk("m_gerr", dbg_err, (m_own == 2) && expire);
    chk("m_gdata", dbg_data, ((m_own == 2) && d_ack) ? d_data : 32'h0);
    if (fin && m_own == 1) c_pend = 1'b0;
    if (fin && m_own == 2) g_pend = 1'b0;
    // What the coming clock edge does to the port.
    if (busy) begin
      if (fin) m_own = 0;
      else     m_age++;
    end else if (cpu_access || dbg_access) begin
      if (cpu_access && dbg_access) m_own = RR_EN ? ((m_last == 1) ? 2 : 1) : 2;
      else                          m_own = cpu_access ? 1 : 2;
      m_last = m_own;
      m_age  = 0;
      m_addr = (m_own == 1) ? cpu_addr    : dbg_addr;
      m_val  = (m_own == 1) ? cpu_wr_val  : dbg_wr_val;
      m_wr   = (m_own == 1) ? cpu_wr_en   : dbg_wr_en;
      m_bs   = (m_own == 1) ? cpu_bytesel : dbg_bytesel;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              ca   cw   caddr        da   dack ddata          dacc daddr      dwr  dbs   cack cdata          gack gdata
    vecs[0]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b1, 32'h55,       1'b0, 32'h0,   1'b0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0,        1'b1, 32'h40,  1'b0, 4'hF, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h44, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 32'h40,  1'b0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,        1'b0, 32'h40,  1'b0, 4'hF, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,        1'b0, 32'h40,  1'b0, 4'hF, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 1'b1, 4'h3, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'hAAAA5555, 1'b1, 32'h100, 1'b1, 4'h3, 1'b0, 32'h0,        1'b1, 32'hAAAA5555};
    vecs[8]  = '{1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0,        1'b0, 32'h100, 1'b1, 4'h3, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0,        1'b1, 32'h80,  1'b1, 4'hF, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h80, 1'b0, 1'b1, 32'h13579BDF, 1'b1, 32'h80,  1'b1, 4'hF, 1'b1, 32'h13579BDF, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,        1'b0, 32'h80,  1'b1, 4'hF, 1'b0, 32'h0,        1'b0, 32'h0};
    exp_order = RR_EN ? '{2, 1, 2} : '{2, 2, 2};

    // Reset with traffic present: everything must read zero.
    rst_n       = 1'b0;
    cpu_access  = 1'b1;
    cpu_wr_en   = 1'b0;
    cpu_addr    = 32'h40;
    cpu_wr_val  = 32'hA5A5A5A5;
    cpu_bytesel = 4'hF;
    dbg_access  = 1'b1;
    dbg_wr_en   = 1'b1;
    dbg_addr    = 32'h100;
    dbg_wr_val  = 32'h12345678;
    dbg_bytesel = 4'h3;
    d_ack       = 1'b1;
    d_data      = 32'hFFFFFFFF;
    settle();
    chk("rst_dacc", d_access, 1'b0);
    chk("rst_dcs", d_cs, 1'b0);
    chk("rst_daddr", d_addr, 32'h0);
    chk("rst_cack", cpu_ack, 1'b0);
    chk("rst_cdata", cpu_data, 32'h0);
    chk("rst_gack", dbg_ack, 1'b0);
    chk("rst_gdata", dbg_data, 32'h0);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (i > 0) next_cycle();
      cpu_access = vecs[i].ca;
      cpu_wr_en  = vecs[i].cw;
      cpu_addr   = vecs[i].caddr;
      dbg_access = vecs[i].da;
      d_ack      = vecs[i].dack;
      d_data     = vecs[i].ddata;
      settle();
      chk($sformatf("v%0d_dacc", i), d_access, vecs[i].e_dacc);
      chk($sformatf("v%0d_dcs", i), d_cs, vecs[i].e_dacc);
      chk($sformatf("v%0d_daddr", i), d_addr, vecs[i].e_daddr);
      chk($sformatf("v%0d_dwr", i), d_wr_en, vecs[i].e_dwr);
      chk($sformatf("v%0d_dbs", i), d_bytesel, vecs[i].e_dbs);
      chk($sformatf("v%0d_cack", i), cpu_ack, vecs[i].e_cack);
      chk($sformatf("v%0d_cerr", i), cpu_err, 1'b0);
      chk($sformatf("v%0d_cdata", i), cpu_data, vecs[i].e_cdata);
      chk($sformatf("v%0d_gack", i), dbg_ack, vecs[i].e_gack);
      chk($sformatf("v%0d_gerr", i), dbg_err, 1'b0);
      chk($sformatf("v%0d_gdata", i), dbg_data, vecs[i].e_gdata);
    end

    dbg_timeout_seq(0);
    dbg_timeout_seq(TMO);

    // Reset pulse in the middle of a CPU transfer, then re-grant.
    next_cycle();
    cpu_access = 1'b1;
    cpu_wr_en  = 1'b0;
    cpu_addr   = 32'h200;
    d_ack      = 1'b0;
    settle();
    next_cycle();
    settle();
    chk("rp_busy", d_access, 1'b1);
    next_cycle();
    d_ack  = 1'b1;
    d_data = 32'h77;
    rst_n  = 1'b0;
    #1;
    chk("rp_dacc", d_access, 1'b0);
    chk("rp_dcs", d_cs, 1'b0);
    chk("rp_daddr", d_addr, 32'h0);
    chk("rp_cack", cpu_ack, 1'b0);
    chk("rp_cerr", cpu_err, 1'b0);
    chk("rp_cdata", cpu_data, 32'h0);
    settle();
    rst_n = 1'b1;
    d_ack = 1'b0;
    next_cycle();
    settle();
    chk("rp_hold", d_access, 1'b0);
    next_cycle();
    settle();
    chk("rp_regrant", d_access, 1'b1);
    chk("rp_regrant_addr", d_addr, 32'h200);
    next_cycle();
    d_ack  = 1'b1;
    d_data = 32'h600DF00D;
    settle();
    chk("rp_cack2", cpu_ack, 1'b1);
    chk("rp_cdata2", cpu_data, 32'h600DF00D);
    next_cycle();
    cpu_access = 1'b0;
    d_ack      = 1'b0;
    settle();

    // Both masters request together and keep requesting for three transfers.
    next_cycle();
    cpu_access = 1'b1;
    cpu_addr   = 32'h300;
    dbg_access = 1'b1;
    d_ack      = 1'b0;
    settle();
    n_got = 0;
    for (int c = 0; c < 40 && n_got < 3; c++) begin
      next_cycle();
      d_ack  = d_access;
      d_data = 32'(c);
      settle();
      if (cpu_ack) begin
        got[n_got] = 1;
        n_got++;
      end else if (dbg_ack) begin
        got[n_got] = 2;
        n_got++;
      end
    end
    chk("tie_count", 32'(n_got), 32'd3);
    for (int i = 0; i < n_got; i++) chk($sformatf("tie_grant%0d", i), 32'(got[i]), 32'(exp_order[i]));
    next_cycle();
    cpu_access = 1'b0;
    dbg_access = 1'b0;
    d_ack      = 1'b0;
    settle();

    // Randomized traffic against the model, from a fresh reset.
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n  = 1'b1;
    m_own  = 0;
    m_age  = 0;
    m_last = 1;
    c_pend = 1'b0;
    g_pend = 1'b0;
    for (int c = 0; c < 800; c++) begin
      next_cycle();
      if (!c_pend && $urandom_range(0, 3) == 0) begin
        c_pend      = 1'b1;
        cpu_addr    = $urandom;
        cpu_wr_en   = 1'($urandom_range(0, 1));
        cpu_wr_val  = $urandom;
        cpu_bytesel = 4'($urandom_range(0, 15));
      end
      if (!g_pend && $urandom_range(0, 3) == 0) begin
        g_pend      = 1'b1;
        dbg_addr    = $urandom;
        dbg_wr_en   = 1'($urandom_range(0, 1));
        dbg_wr_val  = $urandom;
        dbg_bytesel = 4'($urandom_range(0, 15));
      end
      cpu_access = c_pend;
      dbg_access = g_pend;
      d_ack  = (c < 400) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 11) == 0);
      d_data = $urandom;
      settle();
      model_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
